// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and sizing for the register hazard scoreboard.
package hazard_scoreboard_pkg;
  localparam int NUM_REGS     = 32;
  localparam int REG_IDX_W    = $clog2(NUM_REGS);
  localparam int MAX_INFLIGHT = 3;
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0]     sb_cnt_t;

  localparam sb_cnt_t CNT_MAX = sb_cnt_t'(MAX_INFLIGHT);
endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/issue/retire bundle between the pipeline and the hazard scoreboard.
interface hazard_scoreboard_if;
  logic                                           decValid;
  hazard_scoreboard_pkg::reg_idx_t                decRs1;
  logic                                           decRs1Used;
  hazard_scoreboard_pkg::reg_idx_t                decRs2;
  logic                                           decRs2Used;
  hazard_scoreboard_pkg::reg_idx_t                decRd;
  logic                                           decRdWe;
  logic                                           issueFire;
  logic                                           retireValid;
  hazard_scoreboard_pkg::reg_idx_t                retireRd;
  logic                                           flushAll;
  logic                                           stall;
  logic [hazard_scoreboard_pkg::NUM_REGS-1:0]     pendingMask;
  logic                                           errUnderflow;
  logic                                           errOverflow;

  modport master (
    output decValid, decRs1, decRs1Used, decRs2, decRs2Used, decRd, decRdWe,
           issueFire, retireValid, retireRd, flushAll,
    input  stall, pendingMask, errUnderflow, errOverflow
  );

  modport slave (
    input  decValid, decRs1, decRs1Used, decRs2, decRs2Used, decRd, decRdWe,
           issueFire, retireValid, retireRd, flushAll,
    output stall, pendingMask, errUnderflow, errOverflow
  );
endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One register's in-flight write counter: saturating up/down with flush-to-zero.
module sb_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    inc_i,
  input  logic    dec_i,
  input  logic    flush_i,
  output sb_cnt_t cnt_o,
  output logic    busy_o,
  output logic    ovf_o,
  output logic    unf_o
);
  sb_cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    unf_o = 1'b0;
    // Simultaneous issue and retire cancel out and never flag an error.
    if (inc_i && !dec_i) begin
      if (cnt_q == CNT_MAX) ovf_o = 1'b1;
      else                  cnt_d = cnt_q + sb_cnt_t'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) unf_o = 1'b1;
      else             cnt_d = cnt_q - sb_cnt_t'(1);
    end
    if (flush_i) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline interlock: per-register writer counters, decode stall and sticky error flags.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  hazard_scoreboard_if.slave sb
);
  logic    [NUM_REGS-1:0] inc, dec, busy, ovf, unf;
  sb_cnt_t [NUM_REGS-1:0] cnt;
  logic                   raw, waw, stall;
  logic                   errOvf_q, errOvf_d, errUnf_q, errUnf_d;

  // x0 is hardwired idle so every lookup below can index cnt directly.
  assign inc[0]  = 1'b0;
  assign dec[0]  = 1'b0;
  assign busy[0] = 1'b0;
  assign ovf[0]  = 1'b0;
  assign unf[0]  = 1'b0;
  assign cnt[0]  = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
    assign inc[r] = sb.issueFire & sb.decRdWe & (sb.decRd == reg_idx_t'(r));
    assign dec[r] = sb.retireValid & (sb.retireRd == reg_idx_t'(r));

    sb_entry u_ent (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (inc[r]),
      .dec_i   (dec[r]),
      .flush_i (sb.flushAll),
      .cnt_o   (cnt[r]),
      .busy_o  (busy[r]),
      .ovf_o   (ovf[r]),
      .unf_o   (unf[r])
    );
  end

  // Stall sees only registered counts, so a retire unblocks decode one cycle later.
  always_comb begin
    raw = (sb.decRs1Used & (sb.decRs1 != '0) & (cnt[sb.decRs1] != '0))
        | (sb.decRs2Used & (sb.decRs2 != '0) & (cnt[sb.decRs2] != '0));
    waw = sb.decRdWe & (sb.decRd != '0) & (cnt[sb.decRd] == CNT_MAX);
    stall = rst & sb.decValid & (raw | waw);
  end

  always_comb begin
    errOvf_d = errOvf_q | (sb.issueFire & stall) | (|ovf);
    errUnf_d = errUnf_q | (|unf);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      errOvf_q <= 1'b0;
      errUnf_q <= 1'b0;
    end else begin
      errOvf_q <= errOvf_d;
      errUnf_q <= errUnf_d;
    end
  end

  assign sb.stall        = stall;
  assign sb.pendingMask  = busy;
  assign sb.errOverflow  = errOvf_q;
  assign sb.errUnderflow = errUnf_q;
endmodule
